// File: rtl/xoodoo_rdi_gen_if.sv
// Randomness-delivery bus between the seed/consumer side and the xorshift128 RDI generator.
interface xoodoo_rdi_gen_if;
  logic [31:0]  seed;
  logic         seed_valid;
  logic         enable;
  logic [383:0] rdi;
  logic         rdi_valid;
  logic         rdi_ready;
  logic         seeded;
  logic [15:0]  blk_cnt;

  modport slave (
    input  seed, seed_valid, enable, rdi_ready,
    output rdi, rdi_valid, seeded, blk_cnt
  );

  modport master (
    output seed, seed_valid, enable, rdi_ready,
    input  rdi, rdi_valid, seeded, blk_cnt
  );
endinterface

// File: rtl/xoodoo_rdi_gen.sv
// Xorshift128 generator filling 384-bit randomness blocks for a masked Xoodoo core.
// Twelve 32-bit words are gathered per block, then moved to a valid/ready output register.
module xoodoo_rdi_gen (
  input  logic              clk_i,
  input  logic              rst_i,
  xoodoo_rdi_gen_if.slave   bus
);

  typedef enum logic [1:0] {StUnseeded, StSeeding, StRun} state_e;

  localparam logic [31:0] Golden   = 32'h9E3779B9;
  localparam logic [3:0]  FillFull = 4'd12;

  state_e       state_q, state_d;
  logic [31:0]  x_q, x_d, y_q, y_d, z_q, z_d, w_q, w_d;
  logic [1:0]   seed_cnt_q, seed_cnt_d;
  logic [3:0]   fill_cnt_q, fill_cnt_d;
  logic [383:0] fill_q, fill_d;
  logic [383:0] rdi_q, rdi_d;
  logic         rdi_valid_q, rdi_valid_d;
  logic [15:0]  blk_cnt_q, blk_cnt_d;

  logic [1:0]   seed_idx;
  logic         hs, xfer, gen;
  logic [31:0]  t, w_new;

  always_comb begin
    t     = x_q ^ (x_q << 11);
    w_new = w_q ^ (w_q >> 19) ^ t ^ (t >> 8);

    // A seed word arriving outside SEEDING always starts a fresh seed at word 0.
    seed_idx = (state_q == StSeeding) ? seed_cnt_q : 2'd0;
    hs       = rdi_valid_q & bus.rdi_ready;
    xfer     = (state_q == StRun) && (fill_cnt_q == FillFull) &&
               (!rdi_valid_q || bus.rdi_ready);
    gen      = (state_q == StRun) && bus.enable && (fill_cnt_q < FillFull);

    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    w_d         = w_q;
    seed_cnt_d  = seed_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    fill_d      = fill_q;
    rdi_d       = rdi_q;
    rdi_valid_d = rdi_valid_q;
    blk_cnt_d   = blk_cnt_q;

    if (bus.seed_valid) begin
      fill_cnt_d  = '0;
      fill_d      = '0;
      rdi_d       = '0;
      rdi_valid_d = 1'b0;
      unique case (seed_idx)
        2'd0: x_d = bus.seed;
        2'd1: y_d = bus.seed;
        2'd2: z_d = bus.seed;
        2'd3: w_d = ((x_q | y_q | z_q | bus.seed) == '0) ? Golden : bus.seed;
        default: ;
      endcase
      if (seed_idx == 2'd3) begin
        state_d    = StRun;
        seed_cnt_d = '0;
        blk_cnt_d  = '0;
      end else begin
        state_d    = StSeeding;
        seed_cnt_d = seed_idx + 2'd1;
      end
    end else if (state_q == StRun) begin
      if (xfer) begin
        rdi_d       = fill_q;
        rdi_valid_d = 1'b1;
        fill_cnt_d  = '0;
      end else if (hs) begin
        rdi_valid_d = 1'b0;
      end
      if (gen) begin
        x_d = y_q;
        y_d = z_q;
        z_d = w_q;
        w_d = w_new;
        for (int i = 0; i < 12; i++) begin
          if (fill_cnt_q == 4'(i)) fill_d[32*i +: 32] = w_new;
        end
        fill_cnt_d = fill_cnt_q + 4'd1;
      end
      if (hs && (blk_cnt_q != 16'hFFFF)) blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StUnseeded;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      w_q         <= '0;
      seed_cnt_q  <= '0;
      fill_cnt_q  <= '0;
      fill_q      <= '0;
      rdi_q       <= '0;
      rdi_valid_q <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      w_q         <= w_d;
      seed_cnt_q  <= seed_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_q      <= fill_d;
      rdi_q       <= rdi_d;
      rdi_valid_q <= rdi_valid_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign bus.rdi       = rdi_q;
  assign bus.rdi_valid = rdi_valid_q;
  assign bus.seeded    = (state_q == StRun);
  assign bus.blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_xoodoo_rdi_gen.sv
// Directed bench for xoodoo_rdi_gen against a software xorshift128 block model.
module tb_xoodoo_rdi_gen;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  xoodoo_rdi_gen_if bus ();

  xoodoo_rdi_gen u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mx, my, mz, mw;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_seed(input logic [31:0] a, b, c, d);
    mx = a;
    my = b;
    mz = c;
    mw = ((a | b | c | d) == 32'h0) ? 32'h9E3779B9 : d;
  endtask

  task automatic model_block(output logic [383:0] blk);
    logic [31:0] t;
    blk = '0;
    for (int i = 0; i < 12; i++) begin
      t  = mx ^ (mx << 11);
      mx = my;
      my = mz;
      mz = mw;
      mw = mw ^ (mw >> 19) ^ t ^ (t >> 8);
      blk[32*i +: 32] = mw;
    end
  endtask

  task automatic seed_word(input logic [31:0] v);
    bus.seed       = v;
    bus.seed_valid = 1'b1;
    tick();
    bus.seed_valid = 1'b0;
  endtask

  localparam logic [31:0] A0 = 32'h075BCD15;
  localparam logic [31:0] A1 = 32'h159A55E5;
  localparam logic [31:0] A2 = 32'h1F123BB5;
  localparam logic [31:0] A3 = 32'h05491333;

  initial begin
    logic [383:0] exp_blk;
    logic         stable;
    int           consumed;
    logic         rdy;

    bus.seed       = '0;
    bus.seed_valid = 1'b0;
    bus.enable     = 1'b1;
    bus.rdi_ready  = 1'b0;

    // Reset, with a seed word presented during reset that must be ignored.
    rst_i = 1'b1;
    tick();
    bus.seed       = 32'hFFFF_FFFF;
    bus.seed_valid = 1'b1;
    bus.rdi_ready  = 1'b1;
    tick();
    bus.seed_valid = 1'b0;
    bus.rdi_ready  = 1'b0;
    chk("rst_valid", bus.rdi_valid, 0);
    chk("rst_seeded", bus.seeded, 0);
    chk("rst_blk_cnt", bus.blk_cnt, 0);
    chk("rst_rdi", bus.rdi, 0);
    rst_i = 1'b0;

    // Known-answer seed; ready low so the first block stays in place.
    model_seed(A0, A1, A2, A3);
    seed_word(A0);
    chk("seeding_not_run", bus.seeded, 0);
    seed_word(A1);
    seed_word(A2);
    seed_word(A3);
    chk("run_seeded", bus.seeded, 1);
    chk("run_valid0", bus.rdi_valid, 0);
    chk("run_blk_cnt0", bus.blk_cnt, 0);
    repeat (12) tick();
    chk("latency_edge12", bus.rdi_valid, 0);
    tick();
    chk("latency_edge13", bus.rdi_valid, 1);
    chk("kat_word0", bus.rdi[31:0], 32'hDCA345EA);
    model_block(exp_blk);
    chk("kat_block0", bus.rdi, exp_blk);

    // Backpressure: block 0 holds for 40 cycles while block 1 fills and stalls.
    stable = 1'b1;
    repeat (40) begin
      tick();
      if (bus.rdi !== exp_blk || bus.rdi_valid !== 1'b1) stable = 1'b0;
    end
    chk("stall_stable", stable, 1);
    chk("stall_blk_cnt", bus.blk_cnt, 0);
    bus.rdi_ready = 1'b1;
    model_block(exp_blk);
    tick();
    chk("release_valid", bus.rdi_valid, 1);
    chk("release_block1", bus.rdi, exp_blk);
    chk("release_blk_cnt", bus.blk_cnt, 1);

    // Reseed with all-zero words mid-fill while a block is still valid.
    bus.rdi_ready = 1'b0;
    repeat (5) tick();
    chk("pre_reseed_valid", bus.rdi_valid, 1);
    model_seed(32'h0, 32'h0, 32'h0, 32'h0);
    seed_word(32'h0);
    chk("reseed_valid_drop", bus.rdi_valid, 0);
    chk("reseed_seeded", bus.seeded, 0);
    seed_word(32'h0);
    seed_word(32'h0);
    seed_word(32'h0);
    chk("reseed_blk_cnt", bus.blk_cnt, 0);
    bus.rdi_ready = 1'b1;
    repeat (12) tick();
    chk("zero_latency12", bus.rdi_valid, 0);
    tick();
    chk("zero_latency13", bus.rdi_valid, 1);
    chk("zero_word0", bus.rdi[31:0], 32'h9E376A7F);
    model_block(exp_blk);
    chk("zero_block0", bus.rdi, exp_blk);
    tick();
    chk("zero_hs_blk_cnt", bus.blk_cnt, 1);
    chk("zero_hs_valid", bus.rdi_valid, 0);

    // Seed and handshake on the same edge: the seed wins, no count.
    for (int i = 0; i < 20 && bus.rdi_valid !== 1'b1; i++) tick();
    chk("zero_block1_valid", bus.rdi_valid, 1);
    seed_word(A0);
    chk("seed_hs_blk_cnt", bus.blk_cnt, 1);
    chk("seed_hs_valid", bus.rdi_valid, 0);
    chk("seed_hs_seeded", bus.seeded, 0);
    seed_word(A1);
    seed_word(A2);
    seed_word(A3);
    model_seed(A0, A1, A2, A3);
    chk("seed_hs_cnt_clear", bus.blk_cnt, 0);

    // Random enable/ready against the in-order scoreboard.
    consumed = 0;
    for (int c = 0; c < 900; c++) begin
      bus.enable    = 1'($urandom_range(0, 1));
      rdy           = 1'($urandom_range(0, 1));
      bus.rdi_ready = rdy;
      if (bus.rdi_valid === 1'b1 && rdy) begin
        model_block(exp_blk);
        chk("rand_block", bus.rdi, exp_blk);
        consumed++;
      end
      tick();
    end
    chk("rand_blk_cnt", bus.blk_cnt, 384'(consumed));
    chk("rand_progress", (consumed > 5), 1);

    // Reset mid-fill: everything clears and stays idle without a reseed.
    bus.enable    = 1'b1;
    bus.rdi_ready = 1'b0;
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_rdi", bus.rdi, 0);
    chk("midrst_valid", bus.rdi_valid, 0);
    chk("midrst_seeded", bus.seeded, 0);
    chk("midrst_blk_cnt", bus.blk_cnt, 0);
    repeat (20) tick();
    chk("midrst_no_output", bus.rdi_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
